// File: rtl/spectrum_readout.sv
// spectrum_readout: sequences the read-out of accumulated power spectra from
// the spectrum RAM, one range bin at a time, and streams each bin as a gapped,
// address-tagged burst to the peak detector.
//
// Optional build macro: SPEC_READOUT_CLEAR_EN. When it is defined, every
// location read is written back with zero READ_LAT cycles after its read, so
// the RAM starts empty for the next accumulation frame. When it is undefined,
// the write port is tied to zero. The read-out stream is the same in both
// builds.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           one-cycle pulse: accumulation frame complete
//   num_rangebins   number of bins to read (0 = no-op), sampled at start
//   ram_rd_*        RAM read strobe/address {bin, point}; data READ_LAT later
//   ram_wr_*        RAM write port (read-clear), data always 0
//   data_valid_out  beat qualifier for D_out / D_addr / RangBin_counts
//   D_out, D_addr   spectrum word and its point address
//   RangBin_counts  1-based bin index of the current beat, 0 when idle
//   busy            read-out in progress (through the done cycle)
//   done            one-cycle pulse after the last beat
module spectrum_readout #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RB_W     = 5,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned GAP      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [RB_W-1:0]        num_rangebins,
  output logic                   ram_rd_en,
  output logic [RB_W+ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0]      ram_rd_data,
  output logic                   ram_wr_en,
  output logic [RB_W+ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0]      ram_wr_data,
  output logic                   data_valid_out,
  output logic [DATA_W-1:0]      D_out,
  output logic [ADDR_W-1:0]      D_addr,
  output logic [RB_W-1:0]        RangBin_counts,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  localparam int unsigned GapW  = (GAP > 1) ? $clog2(GAP) : 1;
  // One stage per cycle of RAM latency plus the D_out register stage.
  localparam int unsigned Depth = READ_LAT + 1;

  logic [1:0]        state_q, state_d;
  logic [RB_W-1:0]   bin_q, bin_d;
  logic [RB_W-1:0]   nbins_q, nbins_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic              tag_v_q    [Depth];
  logic [RB_W-1:0]   tag_bin_q  [Depth];
  logic [ADDR_W-1:0] tag_addr_q [Depth];
  logic              tag_last_q [Depth];

  logic accept;
  logic last_rd;

  // busy covers the tail of the tag pipeline too, so a new frame can only
  // start once the previous one has fully drained.
  assign accept  = start & ~busy_q;
  assign last_rd = ram_rd_en && (bin_q == nbins_q - RB_W'(1)) && (&addr_q);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    nbins_d = nbins_q;
    addr_d  = addr_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (accept && (num_rangebins != '0)) begin
          state_d = StRead;
          bin_d   = '0;
          addr_d  = '0;
          nbins_d = num_rangebins;
        end
      end
      StRead: begin
        addr_d = addr_q + ADDR_W'(1);
        if (&addr_q) begin
          state_d = StGap;
          gap_d   = '0;
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP - 1)) begin
          if (bin_q == nbins_q - RB_W'(1)) begin
            state_d = StIdle;
          end else begin
            state_d = StRead;
            bin_d   = bin_q + RB_W'(1);
            addr_d  = '0;
          end
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    done_d = (accept && (num_rangebins == '0)) ||
             (tag_v_q[READ_LAT] && tag_last_q[READ_LAT]);
    if (accept && (num_rangebins != '0)) begin
      busy_d = 1'b1;
    end else if (done_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    // Capture RAM data in the cycle its tag reaches the second-to-last stage.
    dout_d = tag_v_q[READ_LAT-1] ? ram_rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= '0;
      nbins_q <= '0;
      addr_q  <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      nbins_q <= nbins_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  // Tag pipeline; tags of idle slots are kept at zero so outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < Depth; k++) begin
        tag_v_q[k]    <= 1'b0;
        tag_bin_q[k]  <= '0;
        tag_addr_q[k] <= '0;
        tag_last_q[k] <= 1'b0;
      end
    end else begin
      tag_v_q[0]    <= ram_rd_en;
      tag_bin_q[0]  <= ram_rd_en ? bin_q : '0;
      tag_addr_q[0] <= ram_rd_en ? addr_q : '0;
      tag_last_q[0] <= last_rd;
      for (int k = 1; k < Depth; k++) begin
        tag_v_q[k]    <= tag_v_q[k-1];
        tag_bin_q[k]  <= tag_bin_q[k-1];
        tag_addr_q[k] <= tag_addr_q[k-1];
        tag_last_q[k] <= tag_last_q[k-1];
      end
    end
  end

  assign ram_rd_en      = (state_q == StRead);
  assign ram_rd_addr    = ram_rd_en ? {bin_q, addr_q} : '0;
  assign data_valid_out = tag_v_q[READ_LAT];
  assign D_out          = dout_q;
  assign D_addr         = tag_addr_q[READ_LAT];
  assign RangBin_counts = tag_v_q[READ_LAT] ? tag_bin_q[READ_LAT] + RB_W'(1) : '0;
  assign busy           = busy_q;
  assign done           = done_q;

`ifdef SPEC_READOUT_CLEAR_EN
  // A tag sits in stage READ_LAT-1 exactly READ_LAT cycles after its read.
  assign ram_wr_en   = tag_v_q[READ_LAT-1];
  assign ram_wr_addr = {tag_bin_q[READ_LAT-1], tag_addr_q[READ_LAT-1]};
  assign ram_wr_data = '0;
`else
  assign ram_wr_en   = 1'b0;
  assign ram_wr_addr = '0;
  assign ram_wr_data = '0;
`endif

endmodule

// File: tb/tb_spectrum_readout.sv
module tb_spectrum_readout;

  localparam int G  = 4;
  localparam int PER = 1024 + G;
`ifdef SPEC_READOUT_CLEAR_EN
  localparam bit ClearBuild = 1'b1;
`else
  localparam bit ClearBuild = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic [4:0]  num     [3];
  logic [2:0]  rd_en;
  logic [14:0] rd_addr [3];
  logic [31:0] rd_data [3];
  logic [2:0]  wr_en;
  logic [14:0] wr_addr [3];
  logic [31:0] wr_data [3];
  logic [2:0]  dv;
  logic [31:0] dout    [3];
  logic [9:0]  daddr   [3];
  logic [4:0]  rbc     [3];
  logic [2:0]  busy;
  logic [2:0]  done;

  int checks   = 0;
  int failures = 0;

  // RAM model: word = hash(seed, addr) unless cleared since the last preload.
  int          gen     [3];
  int unsigned seed    [3];
  int          clr_gen [3][32768];
  logic [31:0] pipe    [3][4];
  int          exp_clr [3];  // bins the bench expects to read back as zero

  always #5 clk = ~clk;

  function automatic int rl(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  function automatic logic [31:0] hash(input int unsigned s, input int a);
    logic [31:0] h;
    h = (32'(a) * 32'h9E37_79B1) ^ s;
    return {h[12:0], h[31:13]} ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      pipe[i][0] <= rd_en[i] ? ((clr_gen[i][rd_addr[i]] == gen[i]) ? 32'd0
                                 : hash(seed[i], int'(rd_addr[i]))) : 32'hDEAD_BEEF;
      for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
      if (wr_en[i]) clr_gen[i][wr_addr[i]] <= gen[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) rd_data[i] = pipe[i][rl(i)-1];
  end

  spectrum_readout #(.READ_LAT(2), .GAP(G)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .num_rangebins(num[0]),
    .ram_rd_en(rd_en[0]), .ram_rd_addr(rd_addr[0]), .ram_rd_data(rd_data[0]),
    .ram_wr_en(wr_en[0]), .ram_wr_addr(wr_addr[0]), .ram_wr_data(wr_data[0]),
    .data_valid_out(dv[0]), .D_out(dout[0]), .D_addr(daddr[0]),
    .RangBin_counts(rbc[0]), .busy(busy[0]), .done(done[0]));

  spectrum_readout #(.READ_LAT(1), .GAP(G)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .num_rangebins(num[1]),
    .ram_rd_en(rd_en[1]), .ram_rd_addr(rd_addr[1]), .ram_rd_data(rd_data[1]),
    .ram_wr_en(wr_en[1]), .ram_wr_addr(wr_addr[1]), .ram_wr_data(wr_data[1]),
    .data_valid_out(dv[1]), .D_out(dout[1]), .D_addr(daddr[1]),
    .RangBin_counts(rbc[1]), .busy(busy[1]), .done(done[1]));

  spectrum_readout #(.READ_LAT(4), .GAP(G)) u_dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .num_rangebins(num[2]),
    .ram_rd_en(rd_en[2]), .ram_rd_addr(rd_addr[2]), .ram_rd_data(rd_data[2]),
    .ram_wr_en(wr_en[2]), .ram_wr_addr(wr_addr[2]), .ram_wr_data(wr_data[2]),
    .data_valid_out(dv[2]), .D_out(dout[2]), .D_addr(daddr[2]),
    .RangBin_counts(rbc[2]), .busy(busy[2]), .done(done[2]));

  task automatic preload(input int i);
    gen[i]     = gen[i] + 1;
    seed[i]    = $urandom;
    exp_clr[i] = 0;
  endtask

  // Drives one start and observes the frame cycle by cycle against the
  // timing rules; mid_c > 0 pulses a stray start, rst_c > 0 resets mid-frame.
  task automatic run_frame(input int i, input int n, input int mid_c, input int rst_c,
                           output int serr, output int beats, output int dones,
                           output int done_c, output int first_v, output int rds,
                           output int wrs, output string ferr);
    int r, len, hor, k, j, w, a;
    bit alive, ev, er, ew, ed, eb, bad;
    logic [31:0] ed_w;
    r   = rl(i);
    len = (n == 0) ? 1 : n * 1024 + (n - 1) * G + r + 2;
    hor = (rst_c > 0) ? rst_c + 8 : len + 8;
    serr = 0; beats = 0; dones = 0; done_c = -1; first_v = -1; rds = 0; wrs = 0;
    ferr = "none";
    @(negedge clk);
    start[i] = 1'b1;
    num[i]   = 5'(n);
    for (int c = 1; c <= hor; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start[i] = 1'b0;
        num[i]   = 5'($urandom);
      end
      alive = !(rst_c > 0 && c > rst_c);
      k  = c - (r + 2);
      j  = c - 1;
      w  = c - 1 - r;
      ev = alive && n > 0 && k >= 0 && (k / PER) < n && (k % PER) < 1024;
      er = alive && n > 0 && j >= 0 && (j / PER) < n && (j % PER) < 1024;
      ew = ClearBuild && alive && n > 0 && w >= 0 && (w / PER) < n && (w % PER) < 1024;
      ed = alive && (c == len);
      eb = alive && n > 0 && c <= len;
      bad = 1'b0;
      if (ev) begin
        a    = (k / PER) * 1024 + (k % PER);
        ed_w = ((k / PER) < exp_clr[i]) ? 32'd0 : hash(seed[i], a);
        if (dv[i] !== 1'b1 || dout[i] !== ed_w || daddr[i] !== 10'(k % PER) ||
            rbc[i] !== 5'(k / PER + 1)) bad = 1'b1;
      end else if (dv[i] !== 1'b0 || dout[i] !== 32'd0 || daddr[i] !== 10'd0 ||
                   rbc[i] !== 5'd0) begin
        bad = 1'b1;
      end
      if (rd_en[i] !== er) bad = 1'b1;
      if (er && rd_addr[i] !== 15'((j / PER) * 1024 + (j % PER))) bad = 1'b1;
      if (wr_en[i] !== ew) bad = 1'b1;
      if (ew && (wr_addr[i] !== 15'((w / PER) * 1024 + (w % PER)) || wr_data[i] !== 0))
        bad = 1'b1;
      if (busy[i] !== eb || done[i] !== ed) bad = 1'b1;
      if (bad) begin
        if (serr == 0)
          ferr = $sformatf("c=%0d dv=%b d=%h a=%0d rb=%0d rd=%b wr=%b busy=%b done=%b",
                           c, dv[i], dout[i], daddr[i], rbc[i], rd_en[i], wr_en[i],
                           busy[i], done[i]);
        serr++;
      end
      if (dv[i] === 1'b1) begin
        beats++;
        if (first_v < 0) first_v = c;
      end
      if (done[i] === 1'b1) begin
        dones++;
        done_c = c;
      end
      if (rd_en[i] === 1'b1) rds++;
      if (wr_en[i] === 1'b1) wrs++;
      if (mid_c > 0 && c == mid_c) begin
        start[i] = 1'b1;
        num[i]   = 5'($urandom);
      end
      if (mid_c > 0 && c == mid_c + 1) start[i] = 1'b0;
      if (rst_c > 0 && c == rst_c) rst = 1'b1;
      if (rst_c > 0 && c == rst_c + 1) rst = 1'b0;
    end
    if (ClearBuild && rst_c == 0 && n > exp_clr[i]) exp_clr[i] = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rd_en[i], wr_en[i], dv[i], busy[i], done[i]} !== 5'b0) begin
        failures++;
        $display("FAIL reset_ctrl[%0d]: actual=%b required=00000", i,
                 {rd_en[i], wr_en[i], dv[i], busy[i], done[i]});
      end
      checks++;
      if (dout[i] !== 0 || daddr[i] !== 0 || rbc[i] !== 0 || rd_addr[i] !== 0) begin
        failures++;
        $display("FAIL reset_data[%0d]: actual=%h/%0d/%0d/%0d required=0", i,
                 dout[i], daddr[i], rbc[i], rd_addr[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_main_frame();
    int se, bt, dn, dc, fv, rd, wr;
    string fe;
    preload(0);
    run_frame(0, 3, 0, 0, se, bt, dn, dc, fv, rd, wr, fe);
    checks++;
    if (se !== 0) begin
      failures++;
      $display("FAIL main_stream: errors=%0d required=0 first: %s", se, fe);
    end
    checks++;
    if (bt !== 3072) begin
      failures++;
      $display("FAIL main_beats: actual=%0d required=3072", bt);
    end
    checks++;
    if (dn !== 1 || dc !== 3084) begin
      failures++;
      $display("FAIL main_done: count=%0d cycle=%0d required 1 at 3084", dn, dc);
    end
    checks++;
    if (rd !== 3072) begin
      failures++;
      $display("FAIL main_reads: actual=%0d required=3072", rd);
    end
  endtask

  task automatic test_zero_bins();
    int se, bt, dn, dc, fv, rd, wr;
    string fe;
    run_frame(0, 0, 0, 0, se, bt, dn, dc, fv, rd, wr, fe);
    checks++;
    if (se !== 0) begin
      failures++;
      $display("FAIL zero_stream: errors=%0d required=0 first: %s", se, fe);
    end
    checks++;
    if (dn !== 1 || dc !== 1 || rd !== 0) begin
      failures++;
      $display("FAIL zero_done: count=%0d cycle=%0d reads=%0d required 1 at 1, 0 reads",
               dn, dc, rd);
    end
  endtask

  task automatic test_mid_start();
    int se, bt, dn, dc, fv, rd, wr, n, mc;
    string fe;
    n  = $urandom_range(1, 3);
    mc = $urandom_range(2, n * 1024);
    preload(0);
    run_frame(0, n, mc, 0, se, bt, dn, dc, fv, rd, wr, fe);
    checks++;
    if (se !== 0) begin
      failures++;
      $display("FAIL mid_start_stream: errors=%0d required=0 first: %s", se, fe);
    end
    checks++;
    if (bt !== n * 1024 || dn !== 1 || dc !== n * 1024 + (n - 1) * G + 4) begin
      failures++;
      $display("FAIL mid_start_len: beats=%0d done=%0d@%0d required %0d, 1@%0d",
               bt, dn, dc, n * 1024, n * 1024 + (n - 1) * G + 4);
    end
  endtask

  task automatic test_reset_mid_frame();
    int se, bt, dn, dc, fv, rd, wr, n;
    string fe;
    preload(0);
    run_frame(0, 3, 0, 2 + 2 + PER + 500, se, bt, dn, dc, fv, rd, wr, fe);
    checks++;
    if (se !== 0) begin
      failures++;
      $display("FAIL rst_mid_stream: errors=%0d required=0 first: %s", se, fe);
    end
    checks++;
    if (dn !== 0 || bt !== 1024 + 501) begin
      failures++;
      $display("FAIL rst_mid_count: done=%0d beats=%0d required 0, %0d", dn, bt, 1525);
    end
    n = $urandom_range(1, 3);
    preload(0);
    run_frame(0, n, 0, 0, se, bt, dn, dc, fv, rd, wr, fe);
    checks++;
    if (se !== 0 || bt !== n * 1024 || dn !== 1) begin
      failures++;
      $display("FAIL rst_fresh_frame: errors=%0d beats=%0d done=%0d required 0,%0d,1 %s",
               se, bt, dn, n * 1024, fe);
    end
  endtask

  task automatic test_read_latency_sweep();
    int se, bt, dn, dc, fv, rd, wr, n;
    string fe;
    for (int i = 1; i < 3; i++) begin
      n = $urandom_range(1, 2);
      preload(i);
      run_frame(i, n, 0, 0, se, bt, dn, dc, fv, rd, wr, fe);
      checks++;
      if (se !== 0) begin
        failures++;
        $display("FAIL lat%0d_stream: errors=%0d required=0 first: %s", rl(i), se, fe);
      end
      checks++;
      if (fv !== rl(i) + 2) begin
        failures++;
        $display("FAIL lat%0d_first_beat: actual=%0d required=%0d", rl(i), fv, rl(i) + 2);
      end
      checks++;
      if (dn !== 1 || dc !== n * 1024 + (n - 1) * G + rl(i) + 2) begin
        failures++;
        $display("FAIL lat%0d_done: count=%0d cycle=%0d required 1 at %0d", rl(i), dn, dc,
                 n * 1024 + (n - 1) * G + rl(i) + 2);
      end
    end
  endtask

  task automatic test_read_clear();
    int se, bt, dn, dc, fv, rd, wr;
    string fe;
    preload(0);
    run_frame(0, 2, 0, 0, se, bt, dn, dc, fv, rd, wr, fe);
    checks++;
    if (se !== 0) begin
      failures++;
      $display("FAIL clear_first_stream: errors=%0d required=0 first: %s", se, fe);
    end
    checks++;
    if (wr !== (ClearBuild ? 2048 : 0)) begin
      failures++;
      $display("FAIL clear_writes: actual=%0d required=%0d", wr, ClearBuild ? 2048 : 0);
    end
    run_frame(0, 2, 0, 0, se, bt, dn, dc, fv, rd, wr, fe);
    checks++;
    if (se !== 0 || bt !== 2048) begin
      failures++;
      $display("FAIL clear_second_stream: errors=%0d beats=%0d required 0,2048 %s",
               se, bt, fe);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 3'b0;
    for (int i = 0; i < 3; i++) begin
      num[i]     = 5'd0;
      gen[i]     = 0;
      exp_clr[i] = 0;
      preload(i);
    end
    test_reset();
    test_main_frame();
    test_zero_bins();
    test_mid_start();
    test_reset_mid_frame();
    test_read_latency_sweep();
    test_read_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
